// File: rtl/ixc_assign_slice.sv
// ixc_assign_slice: DEPTH-stage valid/ready skid-buffer pipeline carrying R to L, optional parity under IXC_ASSIGN_SLICE_PARITY_EN
module ixc_assign_slice #(
  parameter int WIDTH = 288,
  parameter int DEPTH = 1,
  parameter int LW = (DEPTH == 0) ? 1 : $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] R,
  input  logic             r_valid,
  output logic             r_ready,
  output logic [WIDTH-1:0] L,
  output logic             l_valid,
  input  logic             l_ready,
  output logic [LW-1:0]    level
`ifdef IXC_ASSIGN_SLICE_PARITY_EN
  ,
  input  logic             par_inj,
  output logic             par_err
`endif
);
`ifdef IXC_ASSIGN_SLICE_PARITY_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif
  logic [EW-1:0] in_w, out_w;
  assign L = out_w[WIDTH-1:0];
`ifdef IXC_ASSIGN_SLICE_PARITY_EN
  logic par_err_q;
  assign in_w = {^R ^ par_inj, R};
  assign par_err = par_err_q;
  // sticky flag: stored parity disagrees with the word leaving on L
  always_ff @(posedge clk)
    if (rst) par_err_q <= 1'b0;
    else if (l_valid && l_ready && (out_w[WIDTH] != ^out_w[WIDTH-1:0])) par_err_q <= 1'b1;
`else
  assign in_w = R;
`endif
  if (DEPTH == 0) begin : g_pass
    assign out_w = in_w;
    assign l_valid = r_valid;
    assign r_ready = l_ready;
    assign level = '0;
  end else begin : g_pipe
    logic          st_v [DEPTH+1];
    logic          st_r [DEPTH+1];
    logic [EW-1:0] st_d [DEPTH+1];
    logic          hm [DEPTH];
    logic          hs [DEPTH];
    logic [LW-1:0] lvl;
    assign st_v[0] = r_valid;
    assign st_d[0] = in_w;
    assign st_r[DEPTH] = l_ready;
    assign r_ready = st_r[0] && !rst && !flush;
    assign l_valid = st_v[DEPTH] && !flush;
    assign out_w = st_d[DEPTH];
    for (genvar k = 0; k < DEPTH; k++) begin : g_st
      logic          m_v_q, s_v_q, acc, tk;
      logic [EW-1:0] m_d_q, s_d_q;
      assign acc = st_v[k] && !s_v_q;
      assign tk = m_v_q && st_r[k+1];
      assign st_r[k] = !s_v_q;
      assign st_v[k+1] = m_v_q;
      assign st_d[k+1] = m_d_q;
      assign hm[k] = m_v_q;
      assign hs[k] = s_v_q;
      // main/skid update: take drains skid into main, accept fills main first then skid
      always_ff @(posedge clk) begin
        if (rst) begin
          m_v_q <= 1'b0;
          s_v_q <= 1'b0;
          m_d_q <= '0;
          s_d_q <= '0;
        end else if (flush) begin
          m_v_q <= 1'b0;
          s_v_q <= 1'b0;
        end else if (tk) begin
          if (s_v_q) begin
            m_d_q <= s_d_q;
            s_v_q <= 1'b0;
          end else begin
            m_v_q <= acc;
            if (acc) m_d_q <= st_d[k];
          end
        end else if (acc) begin
          if (m_v_q) begin
            s_v_q <= 1'b1;
            s_d_q <= st_d[k];
          end else begin
            m_v_q <= 1'b1;
            m_d_q <= st_d[k];
          end
        end
      end
    end
    // occupancy is the count of valid main and skid entries
    always_comb begin
      lvl = '0;
      for (int i = 0; i < DEPTH; i++) lvl = lvl + LW'(hm[i]) + LW'(hs[i]);
    end
    assign level = lvl;
  end
endmodule

// File: tb/tb_ixc_assign_slice.sv
// tb_ixc_assign_slice: self-checking bench for ixc_assign_slice at DEPTH 0..3
module tb_ixc_assign_slice;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int ncmp = 0, nerr = 0, rc2 = 0, first = -1, cnt = 0, seen = 0;
  logic f2 = 0, rv2 = 0, lr2 = 0, pi2 = 0, rr2, lv2, pe2;
  logic [287:0] r2 = '0, l2;
  logic [2:0] lev2;
  logic f1 = 0, rv1 = 0, lr1 = 0, rr1, lv1, pe1;
  logic [15:0] r1 = '0, l1;
  logic [1:0] lev1;
  logic f3 = 0, rv3 = 0, lr3 = 0, rr3, lv3, pe3;
  logic [7:0] r3 = '0, l3;
  logic [2:0] lev3;
  logic rv0 = 0, lr0 = 0, rr0, lv0, pe0;
  logic [7:0] r0 = '0, l0;
  logic [0:0] lev0;
  logic [287:0] q2[$];
  bit qi2[$];
  bit exp_pe = 0;
  logic [15:0] q1[$];

  ixc_assign_slice #(.WIDTH(288), .DEPTH(2)) u2 (.clk(clk), .rst(rst), .flush(f2), .R(r2), .r_valid(rv2),
    .r_ready(rr2), .L(l2), .l_valid(lv2), .l_ready(lr2), .level(lev2)
`ifdef IXC_ASSIGN_SLICE_PARITY_EN
    , .par_inj(pi2), .par_err(pe2)
`endif
  );
  ixc_assign_slice #(.WIDTH(16), .DEPTH(1)) u1 (.clk(clk), .rst(rst), .flush(f1), .R(r1), .r_valid(rv1),
    .r_ready(rr1), .L(l1), .l_valid(lv1), .l_ready(lr1), .level(lev1)
`ifdef IXC_ASSIGN_SLICE_PARITY_EN
    , .par_inj(1'b0), .par_err(pe1)
`endif
  );
  ixc_assign_slice #(.WIDTH(8), .DEPTH(3)) u3 (.clk(clk), .rst(rst), .flush(f3), .R(r3), .r_valid(rv3),
    .r_ready(rr3), .L(l3), .l_valid(lv3), .l_ready(lr3), .level(lev3)
`ifdef IXC_ASSIGN_SLICE_PARITY_EN
    , .par_inj(1'b0), .par_err(pe3)
`endif
  );
  ixc_assign_slice #(.WIDTH(8), .DEPTH(0)) u0 (.clk(clk), .rst(rst), .flush(1'b0), .R(r0), .r_valid(rv0),
    .r_ready(rr0), .L(l0), .l_valid(lv0), .l_ready(lr0), .level(lev0)
`ifdef IXC_ASSIGN_SLICE_PARITY_EN
    , .par_inj(1'b0), .par_err(pe0)
`endif
  );

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step2();
    logic acc, tk, inj;
    #1;
    chk("u2_level", lev2, q2.size());
    if (lv2) begin
      chk("u2_nonempty", q2.size() != 0, 1);
      if (q2.size() != 0) chk("u2_L", l2, q2[0]);
    end
`ifdef IXC_ASSIGN_SLICE_PARITY_EN
    chk("u2_par_err", pe2, exp_pe);
`endif
    acc = rv2 && rr2;
    tk = lv2 && lr2;
    @(posedge clk); #1;
    if (rst) begin
      q2.delete(); qi2.delete(); exp_pe = 0;
    end else if (f2) begin
      q2.delete(); qi2.delete();
    end else begin
      if (tk && q2.size() != 0) begin
        inj = qi2.pop_front();
        void'(q2.pop_front());
        rc2++;
        if (inj) exp_pe = 1;
      end
      if (acc) begin
        q2.push_back(r2);
        qi2.push_back(pi2);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    chk("rst_rr2", rr2, 0); chk("rst_lv2", lv2, 0); chk("rst_L2", l2, 0); chk("rst_lev2", lev2, 0);
    chk("rst_rr1", rr1, 0); chk("rst_lv1", lv1, 0); chk("rst_L1", l1, 0); chk("rst_lev1", lev1, 0);
    chk("rst_rr3", rr3, 0); chk("rst_L3", l3, 0); chk("rst_lev3", lev3, 0);
`ifdef IXC_ASSIGN_SLICE_PARITY_EN
    chk("rst_par_err", pe2, 0);
`endif
    step2();
    rst = 0; #1;
    chk("rdy_after_rst_u2", rr2, 1); chk("rdy_after_rst_u1", rr1, 1); chk("rdy_after_rst_u3", rr3, 1);
    lr2 = 1;
    for (int i = 0; i < 104; i++) begin
      rv2 = (i < 100);
      r2 = i;
      if (i < 100) chk("u2_no_bubble", rr2, 1);
      step2();
      if (lv2 && first < 0) first = i + 1;
    end
    chk("u2_first_latency", first, 2);
    chk("u2_stream_count", rc2, 100);
    lr2 = 0; rv2 = 1;
    for (int n = 0; n < 10; n++) begin
      if (!rr2) break;
      r2 = 200 + n;
      cnt++;
      step2();
    end
    rv2 = 0;
    chk("u2_bp_accepted", cnt, 4);
    chk("u2_bp_level", lev2, 4);
    lr2 = 1; first = -1;
    for (int j = 0; j < 10; j++) begin
      if (rr2 && first < 0) first = j;
      step2();
    end
    chk("u2_bp_rdy_return", (first >= 0) && (first <= 2), 1);
    chk("u2_drain_level", lev2, 0);
    chk("u2_total_count", rc2, 104);
    for (int i = 0; i < 10000; i++) begin
      logic a, t, e;
      rv1 = 1'($urandom_range(0, 1));
      lr1 = 1'($urandom_range(0, 1));
      r1 = 16'($urandom);
      #1;
      e = q1.size() < 2;
      chk("u1_r_ready", rr1, e);
      chk("u1_l_valid", lv1, q1.size() != 0);
      chk("u1_level", lev1, q1.size());
      if (q1.size() != 0) chk("u1_L", l1, q1[0]);
      lr1 = !lr1; #1;
      chk("u1_r_ready_indep", rr1, e);
      lr1 = !lr1; #1;
      a = rv1 && rr1;
      t = lv1 && lr1;
      @(posedge clk); #1;
      if (t && q1.size() != 0) void'(q1.pop_front());
      if (a) q1.push_back(r1);
    end
    rv1 = 0; lr1 = 0;
    lr3 = 0; rv3 = 1;
    for (int i = 0; i < 5; i++) begin
      r3 = 8'(i + 1);
      chk("u3_fill_rdy", rr3, 1);
      @(posedge clk); #1;
    end
    rv3 = 0;
    chk("u3_level5", lev3, 5);
    f3 = 1; rv3 = 1; r3 = 8'hA5; #1;
    chk("u3_flush_rdy", rr3, 0);
    chk("u3_flush_lv", lv3, 0);
    @(posedge clk); #1;
    f3 = 0; rv3 = 0;
    chk("u3_flush_level", lev3, 0);
    r3 = 8'h3C; rv3 = 1; lr3 = 1;
    @(posedge clk); #1;
    rv3 = 0;
    for (int i = 0; i < 8; i++) begin
      if (lv3) begin
        chk("u3_after_flush_L", l3, 8'h3C);
        seen++;
      end
      @(posedge clk); #1;
    end
    chk("u3_after_flush_seen", seen, 1);
    for (int i = 0; i < 20; i++) begin
      rv0 = 1'($urandom_range(0, 1));
      lr0 = 1'($urandom_range(0, 1));
      r0 = 8'($urandom);
      #1;
      chk("u0_L", l0, r0); chk("u0_l_valid", lv0, rv0); chk("u0_r_ready", rr0, lr0); chk("u0_level", lev0, 0);
      @(posedge clk); #1;
    end
    lr2 = 1; rv2 = 1;
    for (int i = 0; i < 5; i++) begin
      r2 = 500 + i;
      step2();
    end
    rst = 1; #1;
    chk("u2_rdy_in_rst", rr2, 0);
    step2();
    chk("u2_midrst_lv", lv2, 0);
    chk("u2_midrst_level", lev2, 0);
    rst = 0; rv2 = 0; #1;
    chk("u2_rdy_after_midrst", rr2, 1);
`ifdef IXC_ASSIGN_SLICE_PARITY_EN
    for (int i = 0; i < 24; i++) begin
      rv2 = (i < 20);
      r2 = {9{$urandom}};
      pi2 = (i == 7);
      step2();
    end
    rv2 = 0; pi2 = 0;
    chk("u2_par_set", pe2, 1);
    f2 = 1; step2(); f2 = 0; step2();
    chk("u2_par_after_flush", pe2, 1);
    rst = 1; step2(); rst = 0;
    chk("u2_par_after_rst", pe2, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
